// File: rtl/riot_pkg.sv
// Shared decode constants, interval encoding and flag layout for the 6532 RIOT.
package riot_pkg;

  localparam int unsigned A_CS_HI = 12;
  localparam int unsigned A_SEL   = 7;
  localparam int unsigned A_RS    = 9;

  localparam logic [1:0] REG_ORA  = 2'd0;
  localparam logic [1:0] REG_DDRA = 2'd1;
  localparam logic [1:0] REG_ORB  = 2'd2;
  localparam logic [1:0] REG_DDRB = 2'd3;

  localparam int unsigned TIMINT_BIT = 7;
  localparam int unsigned PA7F_BIT   = 6;

  typedef enum logic [1:0] {
    INT_1    = 2'd0,
    INT_8    = 2'd1,
    INT_64   = 2'd2,
    INT_1024 = 2'd3
  } interval_e;

  function automatic logic [9:0] prescale_reload(interval_e iv);
    logic [9:0] n;
    unique case (iv)
      INT_1:    n = 10'd0;
      INT_8:    n = 10'd7;
      INT_64:   n = 10'd63;
      INT_1024: n = 10'd1023;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/riot_6532_if.sv
// CPU-side bus of the RIOT: phase-2 enable, address, data and direction.
interface riot_6532_if;
  logic        ENA;
  logic [12:0] A;
  logic [7:0]  Din;
  logic        R_W_n;
  logic [7:0]  Dout;

  modport master (output ENA, A, Din, R_W_n, input Dout);
  modport slave  (input ENA, A, Din, R_W_n, output Dout);
endinterface

// File: rtl/riot_interval_timer.sv
// Interval timer: prescaler, INTIM down-counter, TIMINT flag and the
// post-underflow switch to a 1-cycle interval.
module riot_interval_timer
  import riot_pkg::*;
#(
  parameter int unsigned SIM_FAST_TIMER = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] load_val,
  input  interval_e  load_iv,
  input  logic       intim_rd,
  output logic [7:0] intim,
  output logic       timint
);

  logic [9:0] presc_q, presc_d;
  logic [7:0] intim_q, intim_d;
  interval_e  iv_q, iv_d;
  logic       one_q, one_d;
  logic       timint_q, timint_d;

  function automatic logic [9:0] reload_of(interval_e iv, logic one);
    return (one || SIM_FAST_TIMER != 0) ? 10'd0 : prescale_reload(iv);
  endfunction

  always_comb begin
    presc_d  = presc_q;
    intim_d  = intim_q;
    iv_d     = iv_q;
    one_d    = one_q;
    timint_d = timint_q;
    if (load) begin
      intim_d  = load_val;
      iv_d     = load_iv;
      one_d    = 1'b0;
      timint_d = 1'b0;
      presc_d  = reload_of(load_iv, 1'b0);
    end else if (ena) begin
      if (intim_rd) timint_d = 1'b0;
      if (presc_q == 10'd0) begin
        intim_d = intim_q - 8'd1;
        presc_d = reload_of(iv_q, one_q);
        // Underflow beats a same-cycle INTIM read clear.
        if (intim_q == 8'd0) begin
          timint_d = 1'b1;
          one_d    = 1'b1;
          presc_d  = 10'd0;
        end
      end else begin
        presc_d = presc_q - 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= 10'd0;
      intim_q  <= 8'd0;
      iv_q     <= INT_1024;
      one_q    <= 1'b0;
      timint_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      intim_q  <= intim_d;
      iv_q     <= iv_d;
      one_q    <= one_d;
      timint_q <= timint_d;
    end
  end

  assign intim  = intim_q;
  assign timint = timint_q;

endmodule

// File: rtl/riot_6532.sv
// 6532 RIOT bus responder: 128 B RAM, two I/O ports with DDRs, interval
// timer and PA7 edge detect, with registered read data.
module riot_6532
  import riot_pkg::*;
#(
  parameter int unsigned RAM_INIT       = 0,
  parameter int unsigned SIM_FAST_TIMER = 0
) (
  input  logic              CLK,
  input  logic              RES,
  riot_6532_if.slave        bus,
  input  logic [7:0]        PA_in,
  output logic [7:0]        PA_out,
  output logic [7:0]        PA_ddr,
  input  logic [7:0]        PB_in,
  output logic [7:0]        PB_out,
  output logic [7:0]        PB_ddr,
  output logic              IRQ_n
);

  logic       cs, rd, wr, ram_sel, io_sel, tmr_sel;
  logic       timer_load, edge_wr, intim_rd, flag_rd, pa7_edge;
  logic [7:0] rdata, flags, intim;
  logic       timint;

  logic [7:0] dout_q, ora_q, ddra_q, orb_q, ddrb_q;
  logic       pa7_q, pa7f_q, pol_q, pa7_ie_q, tim_ie_q, irq_n_q;
  logic [7:0] ram_q [128];
  logic       clr_busy_q;
  logic [6:0] clr_addr_q;

  logic unused_a;
  assign unused_a = ^{bus.A[11:10], bus.A[8], bus.A[5]};

  assign cs         = bus.ENA & ~bus.A[A_CS_HI] & bus.A[A_SEL];
  assign rd         = cs & bus.R_W_n;
  assign wr         = cs & ~bus.R_W_n;
  assign ram_sel    = ~bus.A[A_RS];
  assign io_sel     = bus.A[A_RS] & ~bus.A[2];
  assign tmr_sel    = bus.A[A_RS] & bus.A[2];
  assign timer_load = wr & tmr_sel & bus.A[4];
  assign edge_wr    = wr & tmr_sel & ~bus.A[4];
  assign intim_rd   = rd & tmr_sel & ~bus.A[0];
  assign flag_rd    = rd & tmr_sel & bus.A[0];
  assign pa7_edge   = bus.ENA & (pol_q ? (~pa7_q & PA_in[7]) : (pa7_q & ~PA_in[7]));

  riot_interval_timer #(
    .SIM_FAST_TIMER(SIM_FAST_TIMER)
  ) u_timer (
    .clk      (CLK),
    .rst      (RES),
    .ena      (bus.ENA),
    .load     (timer_load),
    .load_val (bus.Din),
    .load_iv  (interval_e'(bus.A[1:0])),
    .intim_rd (intim_rd),
    .intim    (intim),
    .timint   (timint)
  );

  always_comb begin
    flags             = 8'h00;
    flags[TIMINT_BIT] = timint;
    flags[PA7F_BIT]   = pa7f_q;
    rdata             = 8'h00;
    if (ram_sel) begin
      rdata = clr_busy_q ? 8'h00 : ram_q[bus.A[6:0]];
    end else if (io_sel) begin
      unique case (bus.A[1:0])
        REG_ORA:  rdata = (ora_q & ddra_q) | (PA_in & ~ddra_q);
        REG_DDRA: rdata = ddra_q;
        REG_ORB:  rdata = (orb_q & ddrb_q) | (PB_in & ~ddrb_q);
        REG_DDRB: rdata = ddrb_q;
      endcase
    end else begin
      rdata = bus.A[0] ? flags : intim;
    end
  end

  // RAM has no reset of its own; the optional clear sweeps it after RES.
  always_ff @(posedge CLK) begin
    if (clr_busy_q) begin
      ram_q[clr_addr_q] <= 8'h00;
    end else if (!RES && wr && ram_sel) begin
      ram_q[bus.A[6:0]] <= bus.Din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      clr_busy_q <= (RAM_INIT != 0);
      clr_addr_q <= 7'd0;
    end else if (clr_busy_q) begin
      clr_addr_q <= clr_addr_q + 7'd1;
      if (clr_addr_q == 7'd127) clr_busy_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      dout_q   <= 8'h00;
      ora_q    <= 8'h00;
      ddra_q   <= 8'h00;
      orb_q    <= 8'h00;
      ddrb_q   <= 8'h00;
      pa7_q    <= 1'b0;
      pa7f_q   <= 1'b0;
      pol_q    <= 1'b0;
      pa7_ie_q <= 1'b0;
      tim_ie_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      if (rd) dout_q <= rdata;
      if (wr && io_sel) begin
        unique case (bus.A[1:0])
          REG_ORA:  ora_q  <= bus.Din;
          REG_DDRA: ddra_q <= bus.Din;
          REG_ORB:  orb_q  <= bus.Din;
          REG_DDRB: ddrb_q <= bus.Din;
        endcase
      end
      if (timer_load) tim_ie_q <= bus.A[3];
      if (edge_wr) begin
        pol_q    <= bus.A[0];
        pa7_ie_q <= bus.A[1];
      end
      if (bus.ENA) pa7_q <= PA_in[7];
      if (pa7_edge) pa7f_q <= 1'b1;
      else if (flag_rd) pa7f_q <= 1'b0;
      irq_n_q <= ~((timint & tim_ie_q) | (pa7f_q & pa7_ie_q));
    end
  end

  assign bus.Dout = dout_q;
  assign PA_out   = ora_q;
  assign PA_ddr   = ddra_q;
  assign PB_out   = orb_q;
  assign PB_ddr   = ddrb_q;
  assign IRQ_n    = irq_n_q;

endmodule

// File: tb/tb_riot_6532.sv
// Self-checking bench for riot_6532 against a closed-form behavioural model.
module tb_riot_6532;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pa = 8'h00, pb = 8'h00;
  logic [7:0] pa_out, pa_ddr, pb_out, pb_ddr;
  logic       irq_n;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  riot_6532_if bus();

  riot_6532 dut (
    .CLK    (clk),
    .RES    (rst),
    .bus    (bus.slave),
    .PA_in  (pa),
    .PA_out (pa_out),
    .PA_ddr (pa_ddr),
    .PB_in  (pb),
    .PB_out (pb_out),
    .PB_ddr (pb_ddr),
    .IRQ_n  (irq_n)
  );

  // Model state. Timer: INTIM = load value minus decrements, where decrements
  // come every N ticks until underflow and every tick after it.
  logic [7:0] m_ram [128];
  logic [7:0] m_dout, m_ora, m_ddra, m_orb, m_ddrb;
  bit         m_tie, m_pie, m_pol, m_pa7s, m_pa7f, m_irqn, m_timint;
  int         m_tv, m_tn, m_tk;

  function automatic int dec_count(int k);
    int lim = (m_tv + 1) * m_tn;
    if (k < lim) return k / m_tn;
    return (m_tv + 1) + (k - lim);
  endfunction

  function automatic logic [7:0] model_intim();
    return 8'(m_tv - dec_count(m_tk));
  endfunction

  task automatic model_reset();
    m_dout = 0; m_ora = 0; m_ddra = 0; m_orb = 0; m_ddrb = 0;
    m_tie = 0; m_pie = 0; m_pol = 0; m_pa7s = 0; m_pa7f = 0;
    m_irqn = 1; m_timint = 0;
    m_tv = 0; m_tn = 1; m_tk = 0;
  endtask

  task automatic model_step(input bit ena, input logic [12:0] a, input logic [7:0] din,
                            input bit rw);
    bit cs, rd, wr, irqn_n, edge_seen;
    logic [7:0] rdata, cur, flags;
    cs = ena && !a[12] && a[7];
    rd = cs && rw;
    wr = cs && !rw;
    cur = model_intim();
    flags = {m_timint, m_pa7f, 6'b0};
    if (!a[9]) rdata = m_ram[a[6:0]];
    else if (!a[2]) begin
      case (a[1:0])
        2'd0: rdata = (m_ora & m_ddra) | (pa & ~m_ddra);
        2'd1: rdata = m_ddra;
        2'd2: rdata = (m_orb & m_ddrb) | (pb & ~m_ddrb);
        default: rdata = m_ddrb;
      endcase
    end else rdata = a[0] ? flags : cur;
    irqn_n = !((m_timint && m_tie) || (m_pa7f && m_pie));
    edge_seen = ena && (m_pol ? (!m_pa7s && pa[7]) : (m_pa7s && !pa[7]));
    if (rd) m_dout = rdata;
    if (wr && !a[9]) m_ram[a[6:0]] = din;
    if (wr && a[9] && !a[2]) begin
      case (a[1:0])
        2'd0: m_ora = din;
        2'd1: m_ddra = din;
        2'd2: m_orb = din;
        default: m_ddrb = din;
      endcase
    end
    if (wr && a[9] && a[2] && !a[4]) begin
      m_pol = a[0];
      m_pie = a[1];
    end
    if (wr && a[9] && a[2] && a[4]) begin
      m_tie = a[3];
      m_tv = int'(din);
      m_tn = (a[1:0] == 2'd0) ? 1 : (a[1:0] == 2'd1) ? 8 : (a[1:0] == 2'd2) ? 64 : 1024;
      m_tk = 0;
      m_timint = 0;
    end else if (ena) begin
      bit uf;
      uf = (cur == 8'h00) && (dec_count(m_tk + 1) != dec_count(m_tk));
      m_tk++;
      if (uf) m_timint = 1;
      else if (rd && a[9] && a[2] && !a[0]) m_timint = 0;
    end
    if (edge_seen) m_pa7f = 1;
    else if (rd && a[9] && a[2] && a[0]) m_pa7f = 0;
    if (ena) m_pa7s = pa[7];
    m_irqn = irqn_n;
  endtask

  task automatic cyc(input bit ena, input logic [12:0] a, input logic [7:0] din, input bit rw);
    bus.ENA = ena; bus.A = a; bus.Din = din; bus.R_W_n = rw;
    if (rst) model_reset();
    else model_step(ena, a, din, rw);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d); cyc(1, a, d, 0); endtask
  task automatic rd(input logic [12:0] a); cyc(1, a, 8'h00, 1); endtask
  task automatic idle(); cyc(1, 13'h0000, 8'h00, 1); endtask

  task automatic apply_reset();
    rst = 1;
    idle();
    idle();
    rst = 0;
  endtask

  task automatic test_reset();
    pa = 8'h00; pb = 8'h00;
    apply_reset();
    total++; if (bus.Dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", bus.Dout); end
    total++; if ({pa_out, pa_ddr, pb_out, pb_ddr} !== 32'h0) begin
      bad++; $display("FAIL reset_ports got=%h want=00000000", {pa_out, pa_ddr, pb_out, pb_ddr});
    end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b want=1", irq_n); end
    total++; if (dut.u_timer.intim !== 8'h00 || dut.u_timer.timint !== 1'b0) begin
      bad++; $display("FAIL reset_timer got=%h/%b want=00/0", dut.u_timer.intim, dut.u_timer.timint);
    end
  endtask

  task automatic test_ram();
    wr(13'h0080, 8'h5A);
    rd(13'h0080);
    total++; if (bus.Dout !== 8'h5A) begin bad++; $display("FAIL ram_rd got=%h want=5a", bus.Dout); end
    rd(13'h0100);
    total++; if (bus.Dout !== 8'h5A) begin bad++; $display("FAIL ram_nosel got=%h want=5a", bus.Dout); end
    wr(13'h1080, 8'hFF);
    rd(13'h0080);
    total++; if (bus.Dout !== 8'h5A) begin bad++; $display("FAIL ram_a12 got=%h want=5a", bus.Dout); end
    for (int i = 0; i < 128; i++) wr(13'h0080 | 13'(i), 8'($urandom));
    for (int i = 0; i < 80; i++) begin
      logic [12:0] a;
      a = (13'($urandom) & ~13'h1200) | 13'h0080;
      cyc($urandom_range(0, 3) != 0, a, 8'($urandom), $urandom_range(0, 1) != 0);
      total++; if (bus.Dout !== m_dout) begin
        bad++; $display("FAIL ram_rand got=%h want=%h a=%h", bus.Dout, m_dout, a);
      end
    end
  endtask

  task automatic test_ports();
    pa = 8'h3C;
    wr(13'h0281, 8'hF0);
    wr(13'h0280, 8'hA5);
    rd(13'h0280);
    total++; if (bus.Dout !== 8'hAC) begin bad++; $display("FAIL port_rd got=%h want=ac", bus.Dout); end
    total++; if ({pa_out, pa_ddr} !== 16'hA5F0) begin
      bad++; $display("FAIL port_regs got=%h want=a5f0", {pa_out, pa_ddr});
    end
    for (int i = 0; i < 80; i++) begin
      pa = 8'($urandom); pb = 8'($urandom);
      cyc($urandom_range(0, 3) != 0, 13'h0280 | 13'($urandom_range(0, 3)), 8'($urandom),
          $urandom_range(0, 1) != 0);
      total++; if ({bus.Dout, pa_out, pa_ddr, pb_out, pb_ddr} !==
                   {m_dout, m_ora, m_ddra, m_orb, m_ddrb}) begin
        bad++; $display("FAIL port_rand got=%h want=%h", {bus.Dout, pa_out, pa_ddr, pb_out, pb_ddr},
                        {m_dout, m_ora, m_ddra, m_orb, m_ddrb});
      end
    end
  endtask

  task automatic test_timer8();
    pa = 8'h00; pb = 8'h00;
    apply_reset();
    wr(13'h0295, 8'h02);
    for (int j = 1; j <= 24; j++) begin
      logic [7:0] exp;
      exp = (j <= 8) ? 8'h02 : (j <= 16) ? 8'h01 : 8'h00;
      rd(13'h0284);
      total++; if (bus.Dout !== exp) begin
        bad++; $display("FAIL tmr_seq got=%h want=%h step=%0d", bus.Dout, exp, j);
      end
    end
    total++; if (dut.u_timer.intim !== 8'hFF || dut.u_timer.timint !== 1'b1) begin
      bad++; $display("FAIL tmr_wrap got=%h/%b want=ff/1", dut.u_timer.intim, dut.u_timer.timint);
    end
    rd(13'h0285);
    total++; if (bus.Dout !== 8'h80) begin bad++; $display("FAIL tmr_flags got=%h want=80", bus.Dout); end
    rd(13'h0284);
    total++; if (bus.Dout !== 8'hFE) begin bad++; $display("FAIL tmr_int1 got=%h want=fe", bus.Dout); end
    rd(13'h0285);
    total++; if (bus.Dout !== 8'h00) begin bad++; $display("FAIL tmr_clear got=%h want=00", bus.Dout); end
  endtask

  task automatic test_timer_rand();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      int op;
      logic [12:0] a;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) pa[7] = ~pa[7];
      if (op == 0) begin
        a = 13'h0294 | 13'($urandom_range(0, 1) << 3) | 13'($urandom_range(0, 2));
        wr(a, 8'($urandom_range(0, 6)));
      end else if (op == 1) begin
        wr(13'h0284 | 13'($urandom_range(0, 3)), 8'h00);
      end else if (op <= 4) begin
        cyc($urandom_range(0, 4) != 0, 13'h0284, 8'h00, 1);
      end else if (op <= 6) begin
        cyc($urandom_range(0, 4) != 0, 13'h0285, 8'h00, 1);
      end else begin
        cyc($urandom_range(0, 2) != 0, 13'h0000, 8'h00, 1);
      end
      total++; if ({bus.Dout, irq_n} !== {m_dout, m_irqn}) begin
        bad++; $display("FAIL tmr_rand got=%h/%b want=%h/%b cyc=%0d", bus.Dout, irq_n,
                        m_dout, m_irqn, i);
      end
    end
  endtask

  task automatic test_pa7();
    pa = 8'h00;
    apply_reset();
    wr(13'h0297, 8'hFF);
    wr(13'h0287, 8'h00);
    idle();
    pa = 8'h80;
    idle();
    idle();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL pa7_irq got=%b want=0", irq_n); end
    rd(13'h0285);
    total++; if (bus.Dout !== 8'h40) begin bad++; $display("FAIL pa7_flag got=%h want=40", bus.Dout); end
    idle();
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL pa7_irq_clr got=%b want=1", irq_n); end
    rd(13'h0285);
    total++; if (bus.Dout !== 8'h00) begin bad++; $display("FAIL pa7_clear got=%h want=00", bus.Dout); end
  endtask

  task automatic test_reset_mid();
    wr(13'h0080, 8'h77);
    wr(13'h0281, 8'hFF); wr(13'h0280, 8'h12);
    wr(13'h0283, 8'hFF); wr(13'h0282, 8'h34);
    wr(13'h029F, 8'h40);
    rd(13'h0080);
    idle(); idle();
    total++; if (dut.u_timer.intim !== 8'h40 || bus.Dout !== 8'h77) begin
      bad++; $display("FAIL mid_count got=%h/%h want=40/77", dut.u_timer.intim, bus.Dout);
    end
    rst = 1;
    cyc(1, 13'h0284, 8'h00, 1);
    rst = 0;
    total++; if (dut.u_timer.intim !== 8'h00 || dut.u_timer.timint !== 1'b0) begin
      bad++; $display("FAIL mid_timer got=%h/%b want=00/0", dut.u_timer.intim, dut.u_timer.timint);
    end
    total++; if ({bus.Dout, pa_out, pa_ddr, pb_out, pb_ddr, irq_n} !== 41'h1) begin
      bad++; $display("FAIL mid_regs got=%h want=1", {bus.Dout, pa_out, pa_ddr, pb_out, pb_ddr, irq_n});
    end
  endtask

  initial begin
    bus.ENA = 1'b0; bus.A = 13'h0; bus.Din = 8'h0; bus.R_W_n = 1'b1;
    model_reset();
    test_reset();
    test_ram();
    test_ports();
    test_timer8();
    test_timer_rand();
    test_pa7();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
